// File: rtl/branch_pkg.sv
// Shared types for the branch resolver: the in-flight prediction entry, redirect reasons,
// and the sequential-PC helper.
package branch_pkg;

    localparam int unsigned PC_W      = 32;
    // Entry targets are held at this width; narrower TARGET_WIDTH values are zero-extended.
    localparam int unsigned TGT_MAX_W = 64;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic                 predTaken;
        logic [TGT_MAX_W-1:0] predTarget;
    } predEntry_t;

    typedef enum logic [1:0] {
        RedirNone      = 2'd0,
        RedirDirection = 2'd1,
        RedirTarget    = 2'd2
    } redirect_reason_e;

    function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// Circular buffer of in-flight predictions. Pointers carry one extra wrap bit so a full
// buffer can be told apart from an empty one; flush discards everything still queued.
module pred_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_write;

    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                      (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);
    assign rdata_o  = mem_q[rd_ptr_q[IdxW-1:0]];
    assign do_write = push_i && !full_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            // Head pop and discard of the remainder collapse into one pointer move.
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Matches resolved branches against queued predictions, emits the registered training
// update and mispredict redirect. Define BRANCH_STATS_EN to build the statistics counters.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned TARGET_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetchValid,
    input  logic [31:0]             fetchPc,
    input  logic                    fetchHit,
    input  logic [TARGET_WIDTH-1:0] fetchTarget,
    output logic                    fetchReady,
    input  logic                    resValid,
    input  logic                    resBranch,
    input  logic                    resTaken,
    input  logic [TARGET_WIDTH-1:0] resTarget,
    output logic                    exBranch,
    output logic                    exTaken,
    output logic [31:0]             exPc,
    output logic [TARGET_WIDTH-1:0] exTarget,
    output logic                    redirect,
    output logic [31:0]             redirectPc,
    output logic [31:0]             statBranches,
    output logic [31:0]             statMispredicts
);

    localparam int unsigned EntryW = PC_W + 1 + TARGET_WIDTH;

    logic                    fifo_full, fifo_empty;
    logic [EntryW-1:0]       fifo_wdata, fifo_rdata;
    logic                    do_push, do_pop;
    logic                    actual_taken, mispredict;
    logic [TGT_MAX_W-1:0]    res_target_ext;
    predEntry_t              head;
    redirect_reason_e        reason;

    logic                    ex_branch_q, ex_branch_d;
    logic                    ex_taken_q, ex_taken_d;
    logic [31:0]             ex_pc_q, ex_pc_d;
    logic [TARGET_WIDTH-1:0] ex_target_q, ex_target_d;
    logic                    redirect_q, redirect_d;
    logic [31:0]             redirect_pc_q, redirect_pc_d;

    assign fetchReady     = !fifo_full;
    assign do_pop         = resValid && !fifo_empty;
    // An enqueue in the mispredict cycle belongs to the wrong path.
    assign do_push        = fetchValid && fetchReady && !mispredict;
    assign fifo_wdata     = {fetchPc, fetchHit, fetchTarget};
    assign actual_taken   = resBranch && resTaken;
    assign res_target_ext = TGT_MAX_W'(resTarget);

    pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_pred_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (do_push),
        .wdata_i (fifo_wdata),
        .pop_i   (do_pop),
        .flush_i (mispredict),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        head.pc         = fifo_rdata[EntryW-1 -: PC_W];
        head.predTaken  = fifo_rdata[TARGET_WIDTH];
        head.predTarget = TGT_MAX_W'(fifo_rdata[TARGET_WIDTH-1:0]);
    end

    always_comb begin
        reason = RedirNone;
        if (do_pop) begin
            if (head.predTaken != actual_taken) begin
                reason = RedirDirection;
            end else if (actual_taken && (head.predTarget != res_target_ext)) begin
                reason = RedirTarget;
            end
        end
    end

    assign mispredict = (reason != RedirNone);

    always_comb begin
        ex_branch_d   = 1'b0;
        ex_taken_d    = 1'b0;
        ex_pc_d       = ex_pc_q;
        ex_target_d   = ex_target_q;
        redirect_d    = mispredict;
        redirect_pc_d = redirect_pc_q;
        if (do_pop) begin
            ex_branch_d = resBranch;
            ex_taken_d  = actual_taken;
            ex_pc_d     = head.pc;
            ex_target_d = resTarget;
        end
        if (mispredict) begin
            redirect_pc_d = actual_taken ? PC_W'(resTarget) : seq_pc(head.pc);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_branch_q   <= 1'b0;
            ex_taken_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_target_q   <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            ex_branch_q   <= ex_branch_d;
            ex_taken_q    <= ex_taken_d;
            ex_pc_q       <= ex_pc_d;
            ex_target_q   <= ex_target_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign exBranch   = ex_branch_q;
    assign exTaken    = ex_taken_q;
    assign exPc       = ex_pc_q;
    assign exTarget   = ex_target_q;
    assign redirect   = redirect_q;
    assign redirectPc = redirect_pc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (do_pop && resBranch && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (mispredict && (stat_mp_q != '1)) begin
            stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign statBranches    = stat_br_q;
    assign statMispredicts = stat_mp_q;
`else
    assign statBranches    = '0;
    assign statMispredicts = '0;
`endif

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning in-flight prediction entries (power of two, >=2).
REQ-002 SHALL have parameter TARGET_WIDTH, default 32, meaning the width of predicted and actual target addresses.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fetchValid  input  1  the fetch stage issues one instruction this cycle.
REQ-006 SHALL have port fetchPc  input  32  the PC of the fetched instruction.
REQ-007 SHALL have port fetchHit  input  1  the predictor's predicted-taken flag for fetchPc.
REQ-008 SHALL have port fetchTarget  input  TARGET_WIDTH  the predictor's predicted target.
REQ-009 SHALL have port fetchReady  output  1  the queue can accept an enqueue this cycle.
REQ-010 SHALL have port resValid  input  1  execute resolves the oldest in-flight instruction.
REQ-011 SHALL have port resBranch  input  1  the resolved instruction is a branch or jump.
REQ-012 SHALL have port resTaken  input  1  the actual branch outcome.
REQ-013 SHALL have port resTarget  input  TARGET_WIDTH  the actual branch target.
REQ-014 SHALL have ports exBranch, exTaken (output, 1 bit each), exPc (output, 32 bits) and exTarget (output, TARGET_WIDTH bits), forming the registered predictor-training update.
REQ-015 SHALL have ports redirect (output, 1 bit) and redirectPc (output, 32 bits), the mispredict redirect to fetch.
REQ-016 SHALL have ports statBranches and statMispredicts, output, 32 bits each, the statistics counters.

Function
REQ-017 SHALL enqueue {fetchPc, fetchHit, fetchTarget} when fetchValid && fetchReady; fetchReady = !full, with no same-cycle dequeue bypass.
REQ-018 SHALL, on resValid with the queue non-empty, dequeue the oldest entry and compare it against the resolution.
REQ-019 SHALL define actualTaken = resBranch && resTaken.
REQ-020 SHALL define a mispredict as (predTaken != actualTaken) || (predTaken && actualTaken && predTarget != resTarget).
REQ-021 SHALL, 1 cycle after a resolve, drive exBranch=resBranch, exTaken=actualTaken, exPc=entry pc and exTarget=resTarget; exBranch and exTaken are 0 otherwise, and exPc/exTarget hold their previous values.
REQ-022 SHALL, on a mispredict, pulse redirect for exactly 1 cycle (the cycle after the resolve), with redirectPc = actualTaken ? resTarget : pc+4 (mod 2^32).
REQ-023 SHALL, on a mispredict, flush every remaining entry the same edge, and SHALL drop any enqueue in that cycle.
REQ-024 SHALL ignore resValid when the queue is empty, including when an enqueue occurs the same cycle, so a new entry is never visible before the next cycle.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH and distinguish full from empty with an extra pointer bit.
REQ-026 SHALL, when full, enqueue and dequeue in the same cycle, perform the dequeue only and keep fetchReady low for that cycle.

Reset
REQ-027 SHALL, on rst low, asynchronously clear pointers, redirect, exBranch, exTaken, exPc, exTarget, redirectPc and the stat counters to 0, giving fetchReady=1 after reset.
REQ-028 SHALL discard every in-flight entry when reset asserts mid-operation.

Configuration
REQ-029 SHALL, with BRANCH_STATS_EN defined, increment statBranches on each resolved branch and statMispredicts on each mispredict, each saturating at 32'hFFFFFFFF.
REQ-030 SHALL, without BRANCH_STATS_EN, tie both stat ports to 0 and synthesize no counter logic.

Structure
REQ-031 SHALL define the predEntry_t typedef {pc, predTaken, predTarget} and the redirect-reason constants in the shared package branch_pkg.
REQ-032 SHALL place the circular buffer in a sub-module pred_fifo (parameterised DEPTH, with a flush input), and keep the compare, training and redirect logic in branch_resolver.

Verification
REQ-033 SHALL cover: enqueue pc=0x100, hit=1, target=0x200; resolve branch taken with target 0x200 -> exTaken=1, exPc=0x100, no redirect.
REQ-034 SHALL cover: enqueue pc=0x104, hit=0; resolve branch taken with target 0x180 -> redirect=1, redirectPc=0x180, queue emptied, fetchReady=1.
REQ-035 SHALL cover: enqueue pc=0x108, hit=1, target=0x300; resolve resBranch=0 -> redirect, redirectPc=0x10C, exBranch=0.
REQ-036 SHALL cover: enqueue 8 entries -> fetchReady=0; an enqueue plus resolve in the same cycle -> count becomes 7 and the enqueue is dropped.
REQ-037 SHALL cover: resolve on an empty queue -> no ex/redirect activity; rst low mid-stream -> all outputs 0 and fetchReady=1 while reset is held.
REQ-038 SHALL cover, with BRANCH_STATS_EN: 3 branches including 1 mispredict -> statBranches=3, statMispredicts=1.
